// File: rtl/mips_pkg.sv
// Shared constants for the MEM stage: data memory geometry and WB control bit positions.
package mips_pkg;
  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_AW     = 8;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
endpackage

// File: rtl/data_memory.sv
// 256 x 32 data memory: synchronous write, registered read that returns the pre-write word.
module data_memory
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [DMEM_AW-1:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [DMEM_DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Contents are never cleared; reset only blocks the write port.
  always_ff @(posedge clk) begin
    if (rst_n && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access, branch resolution and the MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN squashes word accesses whose byte offset is nonzero.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] add_result,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic [1:0]  wb_ctl_q,
  output logic [31:0] read_data_q,
  output logic [31:0] alu_result_q,
  output logic [4:0]  wreg_q,
  output logic        misalign_q
);

  logic       misalign;
  logic [1:0] wb_ctl_d;
  logic       unused_addr_bits;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (memread || memwrite) && (alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap the 1 KiB space; the byte offset only matters to the align check.
  assign unused_addr_bits = ^{alu_result[31:10], alu_result[1:0]};

  assign pcsrc         = branch & zero;
  assign branch_target = add_result;

  data_memory u_dmem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (memwrite & ~misalign),
    .re_i    (memread & ~misalign),
    .addr_i  (alu_result[DMEM_AW+1:2]),
    .wdata_i (rdata2out),
    .rdata_o (read_data_q)
  );

  always_comb begin
    wb_ctl_d              = wb_ctlout;
    wb_ctl_d[WB_REGWRITE] = wb_ctlout[WB_REGWRITE] & ~misalign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ctl_q     <= '0;
      alu_result_q <= '0;
      wreg_q       <= '0;
      misalign_q   <= 1'b0;
    end else begin
      wb_ctl_q     <= wb_ctl_d;
      alu_result_q <= alu_result;
      wreg_q       <= five_bit_muxout;
      misalign_q   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: behavioural memory model, per-cycle compare, directed literals.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [1:0]  wb_ctl_q;
  logic [31:0] read_data_q, alu_result_q;
  logic [4:0]  wreg_q;
  logic        misalign_q;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  logic [31:0] mem_m [256];
  logic [1:0]  exp_wb   = '0;
  logic [31:0] exp_rd   = '0;
  logic [31:0] exp_alu  = '0;
  logic [4:0]  exp_wreg = '0;
  logic        exp_mis  = 1'b0;

  mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_ctlout       (wb_ctlout),
    .branch          (branch),
    .memread         (memread),
    .memwrite        (memwrite),
    .zero            (zero),
    .add_result      (add_result),
    .alu_result      (alu_result),
    .rdata2out       (rdata2out),
    .five_bit_muxout (five_bit_muxout),
    .pcsrc           (pcsrc),
    .branch_target   (branch_target),
    .wb_ctl_q        (wb_ctl_q),
    .read_data_q     (read_data_q),
    .alu_result_q    (alu_result_q),
    .wreg_q          (wreg_q),
    .misalign_q      (misalign_q)
  );

  always #5 clk = ~clk;

  function automatic logic is_mis(input logic rd, input logic wr, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (rd || wr) && (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: word index is (address mod 1024) / 4; reads see the word as it was before the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_wb   <= '0;
      exp_rd   <= '0;
      exp_alu  <= '0;
      exp_wreg <= '0;
      exp_mis  <= 1'b0;
    end else begin
      exp_mis  <= is_mis(memread, memwrite, alu_result);
      exp_wb   <= {wb_ctlout[1] & ~is_mis(memread, memwrite, alu_result), wb_ctlout[0]};
      exp_rd   <= (memread && !is_mis(memread, memwrite, alu_result)) ?
                  mem_m[(alu_result % 1024) / 4] : 32'h0;
      exp_alu  <= alu_result;
      exp_wreg <= five_bit_muxout;
      if (memwrite && !is_mis(memread, memwrite, alu_result))
        mem_m[(alu_result % 1024) / 4] <= rdata2out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_ctl_q",      32'(wb_ctl_q),   32'(exp_wb));
      check("read_data_q",   read_data_q,     exp_rd);
      check("alu_result_q",  alu_result_q,    exp_alu);
      check("wreg_q",        32'(wreg_q),     32'(exp_wreg));
      check("misalign_q",    32'(misalign_q), 32'(exp_mis));
      check("pcsrc",         32'(pcsrc),      32'(branch && zero));
      check("branch_target", branch_target,   add_result);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] wb, input logic [4:0] wr_reg);
    memread         = rd;
    memwrite        = wr;
    alu_result      = addr;
    rdata2out       = data;
    wb_ctlout       = wb;
    five_bit_muxout = wr_reg;
    branch          = 1'($urandom_range(0, 1));
    zero            = 1'($urandom_range(0, 1));
    add_result      = $urandom;
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
    step;
    step;
    chk_en = 1'b1;
    check("reset_wb",  32'(wb_ctl_q), 32'h0);
    check("reset_rd",  read_data_q,   32'h0);
    check("reset_alu", alu_result_q,  32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      step;
    end

    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
    step;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd8);
    step;
    check("store_load", read_data_q, 32'hDEADBEEF);

    drive(1'b0, 1'b1, 32'h404, 32'h12345678, 2'b00, 5'd0);
    step;
    drive(1'b1, 1'b0, 32'h004, 32'h0, 2'b11, 5'd9);
    step;
    check("wrap", read_data_q, 32'h12345678);

    drive(1'b0, 1'b1, 32'h20, 32'h1, 2'b00, 5'd0);
    step;
    drive(1'b1, 1'b1, 32'h20, 32'h2, 2'b11, 5'd10);
    step;
    check("rw_old", read_data_q, 32'h1);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd10);
    step;
    check("rw_new", read_data_q, 32'h2);

    branch = 1'b1; zero = 1'b1; add_result = 32'h40;
    #1;
    check("pcsrc_taken", 32'(pcsrc), 32'h1);
    check("target",      branch_target, 32'h40);
    zero = 1'b0;
    #1;
    check("pcsrc_not", 32'(pcsrc), 32'h0);

    drive(1'b0, 1'b1, 32'h80, 32'h55AA, 2'b00, 5'd0);
    step;
    drive(1'b1, 1'b1, 32'h80, 32'hFFFFFFFF, 2'b11, 5'd31);
    branch = 1'b1; zero = 1'b1;
    rst_n = 1'b0;
    step;
    check("rst_wb",   32'(wb_ctl_q),   32'h0);
    check("rst_rd",   read_data_q,     32'h0);
    check("rst_alu",  alu_result_q,    32'h0);
    check("rst_wreg", 32'(wreg_q),     32'h0);
    check("rst_mis",  32'(misalign_q), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h80, 32'h0, 2'b10, 5'd4);
    step;
    check("rst_mem_kept", read_data_q,  32'h55AA);
    check("post_rst_alu", alu_result_q, 32'h80);

    drive(1'b0, 1'b1, 32'h22, 32'h99, 2'b11, 5'd3);
    step;
`ifdef MEM_ALIGN_CHECK_EN
    check("align_flag", 32'(misalign_q), 32'h1);
    check("align_wb",   32'(wb_ctl_q),   32'h1);
`else
    check("align_flag", 32'(misalign_q), 32'h0);
    check("align_wb",   32'(wb_ctl_q),   32'h3);
`endif
    drive(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd3);
    step;
`ifdef MEM_ALIGN_CHECK_EN
    check("align_word", read_data_q, 32'h2);
`else
    check("align_word", read_data_q, 32'h99);
`endif

    for (int n = 0; n < 2000; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      rst_n = ($urandom_range(0, 49) != 0);
      step;
    end

    rst_n = 1'b1;
    step;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports in order: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for the data memory and the MEM/WB register.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 wb_ctlout  input  2  WB control from EX/MEM; bit1 = regwrite, bit0 = memtoreg.
REQ-005 branch, memread, memwrite  input  1 each  MEM controls from EX/MEM.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 add_result  input  32  branch target.
REQ-008 alu_result  input  32  byte address for loads/stores, or the ALU result.
REQ-009 rdata2out  input  32  store data.
REQ-010 five_bit_muxout  input  5  destination register.
REQ-011 pcsrc  output  1  combinational: branch AND zero.
REQ-012 branch_target  output  32  combinational pass-through of add_result.
REQ-013 wb_ctl_q  output  2  registered wb_ctlout.
REQ-014 read_data_q  output  32  registered load data.
REQ-015 alu_result_q  output  32  registered alu_result.
REQ-016 wreg_q  output  5  registered five_bit_muxout.
REQ-017 misalign_q  output  1  registered misaligned-access flag.

Function
REQ-018 Data memory SHALL be 256 x 32-bit words, indexed by alu_result[9:2]; alu_result[31:10] ignored, so addresses wrap modulo 1024 bytes.
REQ-019 When memwrite=1 at a rising edge, mem[alu_result[9:2]] SHALL take rdata2out at that edge.
REQ-020 When memread=1 at a rising edge, read_data_q SHALL take the pre-edge content of mem[alu_result[9:2]]; latency is 1 cycle.
REQ-021 When memread=0, read_data_q SHALL take 0 at the edge.
REQ-022 When memread=1 and memwrite=1 to the same word, the write SHALL occur and read_data_q SHALL return the old (pre-write) value.
REQ-023 wb_ctl_q, alu_result_q and wreg_q SHALL take their inputs on every rising edge with rst_n=1; there is no stall or enable.
REQ-024 pcsrc and branch_target SHALL be purely combinational with no clock dependency.

Reset
REQ-025 With rst_n=0 at an edge, wb_ctl_q, read_data_q, alu_result_q, wreg_q and misalign_q SHALL become 0.
REQ-026 With rst_n=0 at an edge, memory writes SHALL be suppressed, and memory contents SHALL be retained and not cleared.
REQ-027 Reset asserted mid-sequence SHALL discard only the in-flight MEM/WB entry; the first edge after rst_n rises SHALL capture its inputs normally.

Configuration
REQ-028 With macro MEM_ALIGN_CHECK_EN defined, an access (memread or memwrite) with alu_result[1:0] != 0 SHALL suppress the write, force read_data_q to 0, force wb_ctl_q[1] (regwrite) to 0, and set misalign_q=1 for that entry.
REQ-029 Without MEM_ALIGN_CHECK_EN, alu_result[1:0] SHALL be ignored and misalign_q SHALL be constant 0.

Structure
REQ-030 Package mips_pkg SHALL hold DMEM_DEPTH=256, DMEM_AW=8, and the WB bit-position constants WB_REGWRITE=1 and WB_MEMTOREG=0.
REQ-031 The memory array SHALL be a sub-module data_memory (synchronous write, registered read-before-write read); mem_stage instantiates it and holds the MEM/WB register and branch logic.

Verification
REQ-032 Store then load: write 0xDEADBEEF at address 0x10; next cycle memread at 0x10 -> read_data_q=0xDEADBEEF one edge later.
REQ-033 Wrap: write 0x12345678 at 0x404; read at 0x004 -> read_data_q=0x12345678.
REQ-034 Simultaneous access: mem[0x20]=0x1; memread+memwrite at 0x20 with data 0x2 -> read_data_q=0x1, and the following read returns 0x2.
REQ-035 Branch: branch=1, zero=1, add_result=0x40 -> pcsrc=1 and branch_target=0x40 in the same cycle; zero=0 -> pcsrc=0.
REQ-036 Reset: rst_n=0 for one edge with all inputs nonzero -> all registered outputs 0 and the memory word at alu_result unchanged.
REQ-037 With MEM_ALIGN_CHECK_EN: memwrite at 0x22 -> misalign_q=1, wb_ctl_q[1]=0, and word 0x20 unchanged.
